// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, sign-magnitude pre/post fixup.
// Serves DIV/DIVU/REM/REMU; fixed WIDTH+1 cycle latency from the start edge to done.
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             borrow;

    assign a_neg   = is_signed_i & dividend_i[WIDTH-1];
    assign b_neg   = is_signed_i & divisor_i[WIDTH-1];

    // rem < divisor always holds, so a non-borrowing difference fits in WIDTH bits
    assign shifted = {rem_q, q_q[WIDTH-1]};
    assign borrow  = shifted < {1'b0, dvsr_q};
    assign trial   = shifted[WIDTH-1:0] - dvsr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        q_d    = q_q;
        dvsr_d = dvsr_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                qneg_d = is_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                rneg_d = a_neg;
                q_d    = a_neg ? -dividend_i : dividend_i;
                dvsr_d = b_neg ? -divisor_i : divisor_i;
                dz_d   = (divisor_i == '0);
                ovf_d  = is_signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                         && (divisor_i == '1);
                rem_d  = '0;
                cnt_d  = '0;
            end
            CALC: begin
                rem_d = borrow ? shifted[WIDTH-1:0] : trial;
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
            end
            FIX: begin
                // with a zero divisor the shifted-out remainder is |dividend|, so the
                // normal sign fixup already restores the captured dividend
                if (dz_q)       quot_d = '1;
                else if (ovf_q) quot_d = {1'b1, {(WIDTH-1){1'b0}}};
                else            quot_d = qneg_q ? -q_q : q_q;
                remo_d = ovf_q ? '0 : (rneg_q ? -rem_q : rem_q);
                dbz_d  = dz_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            dvsr_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            q_q    <= q_d;
            dvsr_q <= dvsr_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
            done_q <= done_d;
        end
    end

    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring shift-subtract integer divider; the division counterpart of the ripple add/subtract datapath.
- Serves the RV64M DIV/DIVU/REM/REMU ops in the execute stage.
- Produces one quotient bit per cycle using a WIDTH-bit subtract-and-compare step.
- Start/done handshake; the core stalls on busy.

Parameters:
- WIDTH, 64, operand and result width in bits (≥ 4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- is_signed  input  1  1 = two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU); captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient; held until the next done
- remainder  output  WIDTH  registered remainder; held until the next done
- div_by_zero  output  1  registered flag; updated with done

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter/registers=0.
- States:
  - IDLE: on start=1, go to CALC.
  - CALC: runs exactly WIDTH cycles, then goes to FIX.
  - FIX: one cycle, then returns to IDLE.
- Capture, edge N (start=1 in IDLE):
  - Latch sign_q = is_signed & (dividend[MSB] ^ divisor[MSB]).
  - Latch sign_r = is_signed & dividend[MSB].
  - Latch the magnitudes |dividend| and |divisor|; negate only when is_signed=1 and the MSB is set.
  - Latch the special-case flags.
  - Set partial remainder=0, count=0, busy=1.
- CALC, edges N+1..N+WIDTH, each edge:
  - trial = {rem[WIDTH-1:0], q[MSB]} minus divisor, computed at WIDTH+1 bits.
  - If no borrow: rem=trial, shift 1 into q. Otherwise: rem=shifted value, shift 0 into q.
  - count increments.
- FIX, edge N+WIDTH+1:
  - Apply signs: quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem.
  - Register the outputs, set done=1, set busy=0, go to IDLE.
- Timing:
  - done is high only in the cycle following edge N+WIDTH+1, then 0.
  - busy is high from edge N up to edge N+WIDTH+1.
- Latency is fixed at WIDTH+1 edges for all inputs, including the special cases.
- Divide by zero (divisor==0):
  - quotient = all ones; remainder = dividend as captured.
  - div_by_zero=1; the signed/unsigned mode does not change this.
- Signed overflow (is_signed=1, dividend = 1 followed by zeros, divisor = all ones):
  - quotient = dividend; remainder = 0; div_by_zero=0.
- Remainder sign always follows the dividend.
- The magnitude of the remainder is always less than the magnitude of the divisor (RISC-V truncating semantics).
- start while busy=1: ignored. No queuing; the captured operands are not disturbed.
- start in the same cycle done is high: accepted, because the FSM is already IDLE. This gives back-to-back ops with no bubble beyond FIX.
- Input ports may change freely after the capture edge.
- reset asserted mid-operation: immediate abort to the reset values. No done pulse is emitted for the aborted op.
- Outputs quotient, remainder and div_by_zero are not cleared at start; they change only at FIX or reset.

Test Plan:
- Unsigned, WIDTH=64: dividend=100, divisor=7, is_signed=0, start at edge N.
  - Expect busy high through edge N+64.
  - Expect done pulse in the cycle after edge N+65, with quotient=14, remainder=2, div_by_zero=0.
- Signed: dividend=-7, divisor=2.
  - Expect quotient=0xFFFFFFFFFFFFFFFD (-3) and remainder=0xFFFFFFFFFFFFFFFF (-1).
  - Repeat with dividend=7, divisor=-2: expect quotient=-3, remainder=1.
- Divide by zero: dividend=5, divisor=0, in both is_signed values.
  - Expect quotient=0xFFFFFFFFFFFFFFFF, remainder=5, div_by_zero=1.
  - Expect the same done latency of 65 edges.
- Signed overflow: dividend=0x8000000000000000, divisor=0xFFFFFFFFFFFFFFFF, is_signed=1.
  - Expect quotient=0x8000000000000000, remainder=0, div_by_zero=0.
  - Same operands with is_signed=0: expect quotient=0, remainder=0x8000000000000000.
- Handshake:
  - Pulse start again at edge N+10 with different operands: ignored; results match the first op.
  - Pulse start during the done cycle: the second op completes 65 edges later with correct results.
- Reset mid-op: assert reset at edge N+30.
  - Expect busy=0, done=0, outputs=0 immediately.
  - Expect no done pulse afterward.
  - A new start after deassertion completes normally.
- Randomized sweep: 1000 random operand pairs for each mode, checked against the reference model.
